// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 5-stage RV64I pipeline. It owns the PC,
// presents it to a combinational-read instruction memory and registers the
// IF/ID latch consumed by decode. It handles load-use stalls, EX-resolved
// redirects and EBREAK halt, and keeps saturating fetch statistics.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   rst            - synchronous active-high reset
//   imem_addr      - byte address to instruction memory (= pc)
//   imem_rdata     - instruction at imem_addr, valid in the same cycle
//   stall          - load-use stall: holds pc and IF/ID
//   redirect       - taken branch/jump from EX
//   redirect_pc    - redirect target byte address
//   if_pc          - current pc (debug)
//   id_pc          - IF/ID latched pc
//   id_instruction - IF/ID latched instruction
//   id_valid       - IF/ID holds a real instruction (0 = bubble)
//   halted         - fetch is halted on EBREAK
//   misalign_err   - sticky, a redirect target had bits [1:0] != 0
//   fetch_count    - valid instructions latched into IF/ID
//   stall_count    - cycles with stall applied
//   flush_count    - redirects accepted
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013,
    parameter logic [31:0] HALT_INSTR = 32'h00100073,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [63:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             redirect,
    input  logic [63:0]      redirect_pc,
    output logic [63:0]      if_pc,
    output logic [63:0]      id_pc,
    output logic [31:0]      id_instruction,
    output logic             id_valid,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [63:0]       pc, pc_next;
    logic [63:0]       id_pc_next;
    logic [31:0]       id_instruction_next;
    logic              id_valid_next;
    logic              misalign_next;
    logic [CNT_W-1:0]  fetch_next, stall_next, flush_next;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Priority: redirect > stall > halt > normal fetch (rst handled in the
    // register process).
    always_comb begin
        // NOTE: every signal gets a hold default first so no path can infer a latch.
        state_next          = state;
        pc_next             = pc;
        id_pc_next          = id_pc;
        id_instruction_next = id_instruction;
        id_valid_next       = id_valid;
        misalign_next       = misalign_err;
        fetch_next          = fetch_count;
        stall_next          = stall_count;
        flush_next          = flush_count;

        if (redirect) begin
            // The stalled/halting instruction is on the wrong path; flush it.
            pc_next             = {redirect_pc[63:2], 2'b00};
            id_pc_next          = 64'h0;
            id_instruction_next = NOP_INSTR;
            id_valid_next       = 1'b0;
            state_next          = RUN;
            flush_next          = sat_inc(flush_count);
            if (redirect_pc[1:0] != 2'b00)
                misalign_next = 1'b1;
        end else if (stall) begin
            stall_next = sat_inc(stall_count);
        end else if (state == HALTED) begin
            id_pc_next          = pc;
            id_instruction_next = NOP_INSTR;
            id_valid_next       = 1'b0;
        end else begin
            id_pc_next          = pc;
            id_instruction_next = imem_rdata;
            id_valid_next       = 1'b1;
            fetch_next          = sat_inc(fetch_count);
            // EBREAK is latched valid but the pc freezes on it.
            if (imem_rdata == HALT_INSTR)
                state_next = HALTED;
            else
                pc_next = pc + 64'd4;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from pre-edge values.
        if (rst) begin
            state          <= RUN;
            pc             <= RESET_PC;
            id_pc          <= 64'h0;
            id_instruction <= NOP_INSTR;
            id_valid       <= 1'b0;
            misalign_err   <= 1'b0;
            fetch_count    <= '0;
            stall_count    <= '0;
            flush_count    <= '0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            id_pc          <= id_pc_next;
            id_instruction <= id_instruction_next;
            id_valid       <= id_valid_next;
            misalign_err   <= misalign_next;
            fetch_count    <= fetch_next;
            stall_count    <= stall_next;
            flush_count    <= flush_next;
        end
    end

    assign imem_addr = pc;
    assign if_pc     = pc;
    assign halted    = (state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A small combinational instruction memory
// answers imem_addr; every step samples outputs 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] EBRK  = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic [63:0] if_pc;
    logic [63:0] id_pc;
    logic [31:0] id_instruction;
    logic        id_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    int tests_run = 0;
    int tests_failed = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_pc          (if_pc),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .id_valid       (id_valid),
        .halted         (halted),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    // Program image; everything not listed reads as a NOP.
    always_comb begin
        case (imem_addr)
            64'h00:  imem_rdata = 32'h00a00093;
            64'h04:  imem_rdata = 32'h00100113;
            64'h08:  imem_rdata = 32'h002081b3;
            64'h0c:  imem_rdata = 32'h00000013;
            64'h20:  imem_rdata = EBRK;
            default: imem_rdata = NOP;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [63:0] pc_e,
                            input logic [31:0] ins_e, input logic v_e);
        check({tag, ".id_pc"}, id_pc, pc_e);
        check({tag, ".id_instruction"}, {32'h0, id_instruction}, {32'h0, ins_e});
        check({tag, ".id_valid"}, {63'h0, id_valid}, {63'h0, v_e});
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] f,
                             input logic [31:0] s, input logic [31:0] fl);
        check({tag, ".fetch_count"}, {32'h0, fetch_count}, {32'h0, f});
        check({tag, ".stall_count"}, {32'h0, stall_count}, {32'h0, s});
        check({tag, ".flush_count"}, {32'h0, flush_count}, {32'h0, fl});
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst.if_pc", if_pc, 64'h0);
        check("rst.imem_addr", imem_addr, 64'h0);
        check_id("rst", 64'h0, NOP, 1'b0);
        check("rst.halted", {63'h0, halted}, 64'h0);
        check("rst.misalign", {63'h0, misalign_err}, 64'h0);
        check_cnt("rst", 0, 0, 0);

        // Free-running fetch, one-cycle latency
        step(); check_id("f0", 64'h0, 32'h00a00093, 1'b1); check("f0.if_pc", if_pc, 64'h4);
        step(); check_id("f1", 64'h4, 32'h00100113, 1'b1);
        step(); check_id("f2", 64'h8, 32'h002081b3, 1'b1); check("f2.if_pc", if_pc, 64'hc);

        // Two stall cycles hold pc and IF/ID
        stall = 1'b1;
        step(); check_id("st0", 64'h8, 32'h002081b3, 1'b1); check("st0.if_pc", if_pc, 64'hc);
        step(); check_id("st1", 64'h8, 32'h002081b3, 1'b1); check("st1.if_pc", if_pc, 64'hc);
        check_cnt("st1", 3, 2, 0);
        stall = 1'b0;
        step(); check_id("resume", 64'hc, 32'h00000013, 1'b1);
        check_cnt("resume", 4, 2, 0);
        check("resume.if_pc", if_pc, 64'h10);

        // Redirect beats a simultaneous stall
        redirect = 1'b1; redirect_pc = 64'h40; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        check("rd40.if_pc", if_pc, 64'h40);
        check_id("rd40", 64'h0, NOP, 1'b0);
        check_cnt("rd40", 4, 2, 1);

        // Run into EBREAK at 0x20
        redirect = 1'b1; redirect_pc = 64'h18;
        step();
        redirect = 1'b0;
        step(); check_id("f18", 64'h18, NOP, 1'b1);
        step(); check_id("f1c", 64'h1c, NOP, 1'b1);
        step(); check_id("ebreak", 64'h20, EBRK, 1'b1);
        check("ebreak.halted", {63'h0, halted}, 64'h1);
        check("ebreak.if_pc", if_pc, 64'h20);
        check_cnt("ebreak", 7, 2, 2);
        for (int i = 0; i < 10; i++) begin
            step();
            check_id("halt", 64'h20, NOP, 1'b0);
            check("halt.if_pc", if_pc, 64'h20);
            check("halt.halted", {63'h0, halted}, 64'h1);
        end
        check_cnt("halt", 7, 2, 2);

        // Stall while halted only counts
        stall = 1'b1;
        step();
        stall = 1'b0;
        check_id("hstall", 64'h20, NOP, 1'b0);
        check_cnt("hstall", 7, 3, 2);

        // Redirect out of HALTED
        redirect = 1'b1; redirect_pc = 64'h10;
        step();
        redirect = 1'b0;
        check("unhalt.halted", {63'h0, halted}, 64'h0);
        check("unhalt.if_pc", if_pc, 64'h10);
        step(); check_id("f10", 64'h10, NOP, 1'b1);
        check("f10.if_pc", if_pc, 64'h14);
        check_cnt("f10", 8, 3, 3);

        // Misaligned redirect, sticky error
        redirect = 1'b1; redirect_pc = 64'h46;
        step();
        check("mis.if_pc", if_pc, 64'h44);
        check("mis.err", {63'h0, misalign_err}, 64'h1);
        redirect_pc = 64'h40;
        step();
        check("mis2.if_pc", if_pc, 64'h40);
        check("mis2.err", {63'h0, misalign_err}, 64'h1);
        redirect_pc = 64'h18;
        step();
        redirect = 1'b0;
        check("pre_rst.if_pc", if_pc, 64'h18);
        check_cnt("pre_rst", 8, 3, 6);

        // Mid-run reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst.if_pc", if_pc, 64'h0);
        check_id("mrst", 64'h0, NOP, 1'b0);
        check("mrst.err", {63'h0, misalign_err}, 64'h0);
        check_cnt("mrst", 0, 0, 0);

        // pc+4 wraps to zero
        redirect = 1'b1; redirect_pc = 64'hffff_ffff_ffff_fffc;
        step();
        redirect = 1'b0;
        check("wrap0.if_pc", if_pc, 64'hffff_ffff_ffff_fffc);
        step();
        check("wrap1.if_pc", if_pc, 64'h0);
        check_id("wrap1", 64'hffff_ffff_ffff_fffc, NOP, 1'b1);
        check_cnt("wrap1", 1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RV64I pipelined CPU. It owns the PC, drives a combinational-read instruction memory, and registers the IF/ID pipeline latch consumed by decode. It handles load-use stalls, branch/jump redirects from EX and EBREAK halt. It also keeps fetch statistics for the Fibonacci regression bench.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) written into IF/ID.
HALT_INSTR, 32'h00100073, EBREAK encoding that stops fetch.
CNT_W, 32, width of statistics counters.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
imem_addr  out  64  byte address to instruction memory; equals current PC, combinational.
imem_rdata  in  32  instruction at imem_addr, valid in the same cycle.
stall  in  1  hazard unit load-use stall; holds PC and IF/ID.
redirect  in  1  taken branch/jump resolved in EX.
redirect_pc  in  64  target byte address for redirect.
if_pc  out  64  current PC (debug visibility).
id_pc  out  64  IF/ID latched PC.
id_instruction  out  32  IF/ID latched instruction.
id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
halted  out  1  fetch is in HALTED state.
misalign_err  out  1  sticky; set on a redirect target with bits [1:0] != 0.
fetch_count  out  CNT_W  valid instructions latched into IF/ID.
stall_count  out  CNT_W  cycles with stall applied.
flush_count  out  CNT_W  redirects accepted.

Behaviour:
- Reset values (rst high at posedge): pc=RESET_PC, id_pc=0, id_instruction=NOP_INSTR, id_valid=0, halted=0, misalign_err=0, all counters=0, state=RUN. Reset overrides every other input. Reset mid-run discards the IF/ID content.
- Latency: an instruction at PC appears on id_instruction one cycle after the PC is presented on imem_addr.
- FSM states:
  - RUN: fetching.
  - HALTED: PC frozen, bubbles injected.
- Per-cycle priority, evaluated in order: rst > redirect > stall > halt > normal.
- redirect=1, any state:
  - pc <= {redirect_pc[63:2],2'b00}.
  - IF/ID <= {0, NOP_INSTR}, id_valid <= 0.
  - state <= RUN; flush_count++.
  - If redirect_pc[1:0] != 0, set misalign_err.
  - redirect overrides a simultaneous stall, because the stalled instruction is on the wrong path.
- stall=1 without redirect: pc, id_pc, id_instruction and id_valid hold; stall_count++. State is unchanged. This also applies in HALTED, where it has no visible effect other than the count.
- RUN normal cycle:
  - id_pc <= pc, id_instruction <= imem_rdata, id_valid <= 1.
  - fetch_count++.
  - If imem_rdata == HALT_INSTR: pc holds and state <= HALTED. EBREAK itself is latched valid. Otherwise pc <= pc+4.
- HALTED without redirect/stall: pc holds; IF/ID <= {pc, NOP_INSTR}, id_valid <= 0.
- A redirect while HALTED resumes RUN, because the EBREAK was speculative past an older branch.
- Arithmetic:
  - pc+4 wraps modulo 2^64; fffffffffffffffc+4 = 0.
  - Counters saturate at all-ones and do not wrap.
- halted = (state == HALTED). if_pc = imem_addr = pc.
- misalign_err is cleared only by rst.

Test Plan:
- Reset then 4 free cycles, imem returning 0x00a00093, 0x00100113, 0x002081b3, 0x00000013 at 0,4,8,12 -> id_pc 0,4,8,12 on cycles 1-4 with matching id_instruction; id_valid=1; fetch_count=4.
- stall high 2 cycles while id_pc=8 -> id_pc/id_instruction hold 8/0x002081b3 and if_pc holds c; stall_count=2; resumes with id_pc=c.
- redirect=1 with redirect_pc=0x40 and stall=1 in the same cycle -> next cycle if_pc=0x40, id_valid=0, id_instruction=0x00000013, stall_count unchanged, flush_count=1.
- EBREAK at 0x20 -> id_instruction=0x00100073 with valid=1, then halted=1, if_pc stays 0x20, and id_valid=0 for 10 cycles. A later redirect to 0x10 -> halted=0 and fetch resumes at 0x10.
- redirect_pc=0x46 -> if_pc=0x44, misalign_err=1 and it stays set after further redirects; rst clears it.
- Assert rst for 1 cycle mid-stream at pc=0x18 -> next cycle if_pc=0, id_valid=0, counters=0. Force pc to fffffffffffffffc via redirect -> next pc=0.
